// File: rtl/alu_disp_pkg.sv
// -----------------------------------------------------------------------------
// alu_disp_pkg
// Shared definitions for the ALU result display:
//   - converter FSM state encoding
//   - BCD digit count and accumulator width
//   - 7-segment code table (active-low, bit0=a .. bit6=g) and blank code
//   - helpers: segment encoding and the double-dabble "add 3" nibble adjust
// -----------------------------------------------------------------------------
package alu_disp_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment codes for digits 0..9.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Segment code for one digit; non-decimal codes show as blank.
  function automatic logic [6:0] seg_code(input logic [3:0] digit,
                                          input logic       blank,
                                          input logic       active_low);
    logic [6:0] raw;
    if (blank) begin
      raw = SEG_BLANK;
    end else if (digit <= 4'd9) begin
      raw = SEG_TABLE[digit];
    end else begin
      raw = SEG_BLANK;
    end
    if (active_low) begin
      return raw;
    end else begin
      return ~raw;
    end
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (res[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = res[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = res[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_result_display_seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
// Combinational BCD digit to 7-segment decoder.
// Ports:
//   digit  in  4  BCD digit (0..9)
//   blank  in  1  force all segments off
//   seg    out 7  segments, bit0=a .. bit6=g; polarity set by SEG_ACTIVE_LOW
// -----------------------------------------------------------------------------
module seven_seg_decoder
  import alu_disp_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup with blanking and output polarity.
  always_comb begin
    seg = seg_code(digit, blank, SEG_ACTIVE_LOW);
  end

endmodule

// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
// Converts the ALU result to decimal with a sequential double-dabble (one bit
// per clock) and drives three 7-segment displays. A one-deep pending buffer
// (latest value wins) holds a result that arrives while a conversion runs.
// Ports:
//   CLK_50        in  1      system clock
//   RESET_N       in  1      asynchronous active-low reset
//   RESULT        in  WIDTH  unsigned ALU result
//   RESULT_VALID  in  1      one-cycle strobe, RESULT is new
//   HEX0/1/2      out 7      ones/tens/hundreds segments (registered)
//   BUSY          out 1      conversion in progress (SHIFT or LATCH)
//   DONE          out 1      one-cycle pulse when the HEX outputs update
// Build option:
//   ALU_DISP_LEADING_ZERO_BLANK_EN - blank leading zero digits on HEX2/HEX1.
// -----------------------------------------------------------------------------
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             CLK_50,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] RESULT,
  input  logic             RESULT_VALID,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic             BUSY,
  output logic             DONE
);

`ifdef ALU_DISP_LEADING_ZERO_BLANK_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  localparam logic [3:0] CNT_LOAD   = 4'(WIDTH);
  localparam logic [6:0] HEX0_RST   = seg_code(4'd0, 1'b0, SEG_ACTIVE_LOW);
  localparam logic [6:0] HEX_HI_RST = seg_code(4'd0, LZ_BLANK, SEG_ACTIVE_LOW);

  disp_state_e              state_r;
  disp_state_e              state_nxt_s;
  logic                     armed_r;
  logic                     accept_s;
  logic [WIDTH-1:0]         bin_r;
  logic [BCD_W-1:0]         bcd_r;
  logic [3:0]               cnt_r;
  logic [WIDTH-1:0]         pend_val_r;
  logic                     pend_full_r;
  logic [BCD_W-1:0]         bcd_adj_s;
  logic [BCD_W+WIDTH-1:0]   cat_s;
  logic [BCD_W+WIDTH-1:0]   cat_sh_s;
  logic                     blank1_s;
  logic                     blank2_s;
  logic [6:0]               seg0_s;
  logic [6:0]               seg1_s;
  logic [6:0]               seg2_s;
  logic [6:0]               hex0_r;
  logic [6:0]               hex1_r;
  logic [6:0]               hex2_r;
  logic                     busy_r;
  logic                     done_r;

  // A strobe is only taken once the first clock after reset release has passed.
  always_comb begin
    accept_s = RESULT_VALID && armed_r;
  end

  // Next-state logic of the converter FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pend_full_r || accept_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_LATCH;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_LATCH: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // One double-dabble step: adjust nibbles, then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj_s = bcd_adjust(bcd_r);
    cat_s     = {bcd_adj_s, bin_r};
    cat_sh_s  = {cat_s[BCD_W+WIDTH-2:0], 1'b0};
  end

  // Leading-zero blanking flags, evaluated on the finished BCD value.
  always_comb begin
    blank2_s = LZ_BLANK && (bcd_r[11:8] == 4'd0);
    blank1_s = LZ_BLANK && (bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0);
  end

  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec0 (
    .digit (bcd_r[3:0]),
    .blank (1'b0),
    .seg   (seg0_s)
  );

  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec1 (
    .digit (bcd_r[7:4]),
    .blank (blank1_s),
    .seg   (seg1_s)
  );

  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec2 (
    .digit (bcd_r[11:8]),
    .blank (blank2_s),
    .seg   (seg2_s)
  );

  // FSM state, post-reset arming flag and registered BUSY/DONE.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      armed_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      armed_r <= 1'b1;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_r == ST_LATCH);
    end
  end

  // Pending buffer: captures strobes while busy; drained first when idle.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_val_r  <= '0;
      pend_full_r <= 1'b0;
    end else if (accept_s && ((state_r != ST_IDLE) || pend_full_r)) begin
      pend_val_r  <= RESULT;
      pend_full_r <= 1'b1;
    end else if (state_r == ST_IDLE) begin
      pend_val_r  <= pend_val_r;
      pend_full_r <= 1'b0;
    end else begin
      pend_val_r  <= pend_val_r;
      pend_full_r <= pend_full_r;
    end
  end

  // Conversion datapath: load in IDLE, one shift per SHIFT cycle.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bin_r <= '0;
      bcd_r <= '0;
      cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pend_full_r) begin
            bin_r <= pend_val_r;
            bcd_r <= '0;
            cnt_r <= CNT_LOAD;
          end else if (accept_s) begin
            bin_r <= RESULT;
            bcd_r <= '0;
            cnt_r <= CNT_LOAD;
          end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
            cnt_r <= cnt_r;
          end
        end
        ST_SHIFT: begin
          bcd_r <= cat_sh_s[BCD_W+WIDTH-1:WIDTH];
          bin_r <= cat_sh_s[WIDTH-1:0];
          cnt_r <= cnt_r - 4'd1;
        end
        default: begin
          bin_r <= bin_r;
          bcd_r <= bcd_r;
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Display registers: only updated in LATCH, so no intermediate BCD is shown.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hex0_r <= HEX0_RST;
      hex1_r <= HEX_HI_RST;
      hex2_r <= HEX_HI_RST;
    end else if (state_r == ST_LATCH) begin
      hex0_r <= seg0_s;
      hex1_r <= seg1_s;
      hex2_r <= seg2_s;
    end else begin
      hex0_r <= hex0_r;
      hex1_r <= hex1_r;
      hex2_r <= hex2_r;
    end
  end

  assign HEX0 = hex0_r;
  assign HEX1 = hex1_r;
  assign HEX2 = hex2_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_alu_result_display.sv
// -----------------------------------------------------------------------------
// tb_alu_result_display
// Self-checking bench for alu_result_display (WIDTH=8, active-low segments).
// A transaction-level model (accept time, completion deadline, one pending
// slot, decimal digits by division) is compared with the DUT outputs on every
// falling clock edge; directed tests add hand-computed literal checks.
// Honours ALU_DISP_LEADING_ZERO_BLANK_EN like the design.
// -----------------------------------------------------------------------------
module tb_alu_result_display;

  localparam int WIDTH = 8;

`ifdef ALU_DISP_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic             CLK_50 = 1'b0;
  logic             RESET_N = 1'b1;
  logic [WIDTH-1:0] RESULT = '0;
  logic             RESULT_VALID = 1'b0;
  logic [6:0]       HEX0, HEX1, HEX2;
  logic             BUSY, DONE;

  int checks = 0;
  int fails  = 0;

  alu_result_display #(.WIDTH(WIDTH), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK_50       (CLK_50),
    .RESET_N      (RESET_N),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .HEX0         (HEX0),
    .HEX1         (HEX1),
    .HEX2         (HEX2),
    .BUSY         (BUSY),
    .DONE         (DONE)
  );

  always #10 CLK_50 = ~CLK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // {HEX2, HEX1, HEX0} for a decimal value.
  function automatic logic [20:0] disp_of(input int v);
    int h, t, o;
    logic [6:0] s2, s1, s0;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    s2 = (LZB && h == 0) ? 7'h7F : seg_of(h);
    s1 = (LZB && h == 0 && t == 0) ? 7'h7F : seg_of(t);
    s0 = seg_of(o);
    return {s2, s1, s0};
  endfunction

  // ---------------- transaction-level model ----------------
  int     m_disp = 0;
  bit     m_done = 1'b0;
  bit     m_busy = 1'b0;
  bit     m_active = 1'b0;
  bit     m_armed = 1'b0;
  bit     m_pfull = 1'b0;
  int     m_cur = 0;
  int     m_pend = 0;
  longint m_edge = 0;
  longint m_finish = 0;

  task automatic model_step();
    if (!RESET_N) begin
      m_disp = 0; m_done = 1'b0; m_busy = 1'b0;
      m_active = 1'b0; m_armed = 1'b0; m_pfull = 1'b0;
    end else begin
      bit acc;
      acc = RESULT_VALID && m_armed;
      m_armed = 1'b1;
      m_edge++;
      m_done = 1'b0;
      if (m_active) begin
        if (m_edge == m_finish) begin
          m_disp = m_cur; m_done = 1'b1; m_active = 1'b0;
        end
        if (acc) begin m_pend = int'(RESULT); m_pfull = 1'b1; end
      end else if (m_pfull) begin
        m_cur = m_pend; m_active = 1'b1; m_finish = m_edge + WIDTH + 1;
        if (acc) m_pend = int'(RESULT);
        else m_pfull = 1'b0;
      end else if (acc) begin
        m_cur = int'(RESULT); m_active = 1'b1; m_finish = m_edge + WIDTH + 1;
      end
      m_busy = m_active;
    end
  endtask

  initial forever begin
    @(posedge CLK_50 or negedge RESET_N);
    model_step();
  end

  task automatic compare_cycle();
    logic [20:0] e;
    e = disp_of(m_disp);
    chk("cyc_hex2", HEX2, e[20:14]);
    chk("cyc_hex1", HEX1, e[13:7]);
    chk("cyc_hex0", HEX0, e[6:0]);
    chk("cyc_busy", BUSY, m_busy);
    chk("cyc_done", DONE, m_done);
  endtask

  initial begin
    @(negedge CLK_50);
    forever begin
      compare_cycle();
      @(negedge CLK_50);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [WIDTH-1:0] v);
    RESULT = v;
    RESULT_VALID = 1'b1;
    @(posedge CLK_50); #1;
    RESULT_VALID = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK_50); #1;
      if (DONE) break;
    end
    chk({name, "_done_seen"}, DONE, 1'b1);
  endtask

  task automatic chk_disp(input string name, input logic [6:0] h2,
                          input logic [6:0] h1, input logic [6:0] h0);
    chk({name, "_hex2"}, HEX2, h2);
    chk({name, "_hex1"}, HEX1, h1);
    chk({name, "_hex0"}, HEX0, h0);
  endtask

  initial begin
    int cyc, busyc, dseen;
    #1 RESET_N = 1'b0;
    repeat (3) @(posedge CLK_50);
    #1;
    chk_disp("rst", LZB ? 7'h7F : 7'h40, LZB ? 7'h7F : 7'h40, 7'h40);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);

    // Strobe in the first cycle after release must be ignored.
    RESET_N = 1'b1;
    RESULT = 8'd55;
    RESULT_VALID = 1'b1;
    @(posedge CLK_50); #1;
    RESULT_VALID = 1'b0;
    dseen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK_50); #1;
      if (BUSY || DONE) dseen++;
    end
    chk("release_ignored", dseen, 0);

    // Single value 13: latency and BUSY length.
    RESULT = 8'd13;
    RESULT_VALID = 1'b1;
    cyc = 0;
    busyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK_50); #1;
      RESULT_VALID = 1'b0;
      cyc++;
      if (BUSY) busyc++;
      if (DONE) break;
    end
    chk("v13_latency", cyc, 10);
    chk("v13_busy_cycles", busyc, 9);
    chk_disp("v13", LZB ? 7'h7F : 7'h40, 7'h79, 7'h30);

    // Maximum value.
    drive(8'd255);
    wait_done("v255");
    chk_disp("v255", 7'h24, 7'h12, 7'h12);

    // Full sweep, checked by the per-cycle model compare.
    for (int v = 0; v < 256; v++) begin
      drive(v[7:0]);
      wait_done("sweep");
    end
    chk_disp("sweep_last", 7'h24, 7'h12, 7'h12);

    // Back-to-back: 30 then 7 two cycles later.
    drive(8'd30);
    @(posedge CLK_50); #1;
    drive(8'd7);
    wait_done("b2b_30");
    chk_disp("b2b_30", LZB ? 7'h7F : 7'h40, 7'h30, 7'h40);
    wait_done("b2b_7");
    chk_disp("b2b_7", LZB ? 7'h7F : 7'h40, LZB ? 7'h7F : 7'h40, 7'h78);

    // Three strobes during one conversion: latest pending wins.
    drive(8'd30);
    @(posedge CLK_50); #1;
    drive(8'd7);
    @(posedge CLK_50); #1;
    drive(8'd200);
    wait_done("tri_30");
    chk_disp("tri_30", LZB ? 7'h7F : 7'h40, 7'h30, 7'h40);
    wait_done("tri_200");
    chk_disp("tri_200", 7'h24, 7'h40, 7'h40);

    // Reset in the middle of converting 99.
    drive(8'd99);
    repeat (3) @(posedge CLK_50);
    #1 RESET_N = 1'b0;
    @(negedge CLK_50); #1;
    chk_disp("midrst", LZB ? 7'h7F : 7'h40, LZB ? 7'h7F : 7'h40, 7'h40);
    chk("midrst_busy", BUSY, 1'b0);
    @(posedge CLK_50); #1;
    RESET_N = 1'b1;
    dseen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK_50); #1;
      if (DONE || BUSY) dseen++;
    end
    chk("midrst_quiet", dseen, 0);
    chk("midrst_hold_hex0", HEX0, 7'h40);

    // Pending full plus a new strobe in the IDLE cycle.
    drive(8'd1);
    @(posedge CLK_50); #1;
    drive(8'd42);
    wait_done("sim_1");
    chk_disp("sim_1", LZB ? 7'h7F : 7'h40, LZB ? 7'h7F : 7'h40, 7'h79);
    drive(8'd128);
    wait_done("sim_42");
    chk_disp("sim_42", LZB ? 7'h7F : 7'h40, 7'h19, 7'h24);
    wait_done("sim_128");
    chk_disp("sim_128", 7'h79, 7'h24, 7'h00);

    repeat (3) @(posedge CLK_50);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Downstream stage of the board ALU: consumes the 8-bit ALU result and drives the three 7-segment displays (HEX2..HEX0) with its decimal value.
- Binary-to-BCD conversion is sequential (shift-and-add-3 / double-dabble, one bit per clock), followed by per-digit segment decoding.
- Has a one-deep pending buffer so results arriving during a conversion are not lost.

Parameters:
- WIDTH, 8, result width in bits; legal 1..9 (three decimal digits always suffice).
- SEG_ACTIVE_LOW, 1, 1 = segment lit on 0 (board default); 0 = inverted outputs.

Ports:
- CLK_50  input  1  system clock, 50 MHz
- RESET_N  input  1  asynchronous, active-low reset
- RESULT  input  WIDTH  unsigned ALU result
- RESULT_VALID  input  1  one-cycle strobe: RESULT is new
- HEX0  output  7  ones digit segments, bit0=a .. bit6=g
- HEX1  output  7  tens digit segments
- HEX2  output  7  hundreds digit segments
- BUSY  output  1  conversion in progress
- DONE  output  1  one-cycle pulse when HEX outputs update

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, pending empty, BUSY=0, DONE=0, displayed BCD=000 → HEX0=HEX1=HEX2=7'h40 (active-low "0").
- Segment codes (active-low) 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). With SEG_ACTIVE_LOW=0 every output bit is inverted.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE: on RESULT_VALID (or pending full) load the shift register with the value, clear BCD accumulator, bit counter=WIDTH, go SHIFT. Pending value has priority over a simultaneous new RESULT_VALID; in that case the new value goes into pending.
- SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {BCD,bin} left by 1; decrement counter. After WIDTH shifts go LATCH.
- LATCH: copy BCD into display register, pulse DONE for one cycle, go IDLE.
- BUSY=1 in SHIFT and LATCH, 0 in IDLE.
- Latency: RESULT_VALID sampled at edge N → HEX outputs change and DONE=1 after edge N+WIDTH+1 (10 cycles for WIDTH=8).
- RESULT_VALID while BUSY: value stored in pending, overwriting any older pending value (latest wins). It is converted immediately after the current LATCH, with no extra IDLE cycle penalty beyond the IDLE state itself.
- HEX outputs are registered and hold their value between conversions; they never show intermediate BCD.
- RESULT_VALID in the same cycle as RESET_N deassertion is ignored.
- Reset asserted mid-conversion: conversion and pending are discarded, and the display returns to "000" immediately.
- Values outside 0..(2^WIDTH−1) are impossible; no overflow handling is needed.

Optional Feature:
- Macro: ALU_DISP_LEADING_ZERO_BLANK_EN.
- Defined: in LATCH, HEX2 is blanked (7'h7F active-low) when hundreds=0, and HEX1 is blanked when hundreds=0 and tens=0. HEX0 is always shown. The reset display is blank, blank, "0".
- Undefined: all three digits are always shown, including leading zeros.

Decomposition:
- Package alu_disp_pkg:
  - state enum (IDLE, SHIFT, LATCH)
  - SEG_BLANK constant
  - 10-entry digit-to-segment constant table
  - BCD_DIGITS=3
- Sub-module seven_seg_decoder: combinational, 4-bit BCD plus blank flag in, 7-bit segments out; instantiated 3×.
- Converter FSM and pending buffer stay in the top module.

Test Plan:
- Reset: hold RESET_N=0 → HEX0/1/2=7'h40, BUSY=0, DONE=0; with the blank macro defined → HEX2=HEX1=7'h7F, HEX0=7'h40.
- Single value: RESULT=13 with one-cycle strobe → exactly 10 cycles later DONE=1; HEX2=7'h40, HEX1=7'h79, HEX0=7'h30; BUSY high for 9 cycles.
- Max value: RESULT=255 → HEX2=7'h24, HEX1=7'h12, HEX0=7'h12. Also sweep 0..255 against a reference model.
- Back-to-back:
  - Strobe 30, then 7 two cycles later → display "030" with DONE, then "007" with a second DONE; both are seen, and 7 is never lost.
  - Strobes 30, 7, 200 during one conversion → display shows 30, then 200.
- Reset mid-operation: strobe 99, assert RESET_N at cycle 4 → outputs return to reset values, no DONE pulse, and no later update without a new strobe.
- Simultaneous: pending full while a new RESULT_VALID arrives in the IDLE cycle → pending value is converted first and the new value second.
